// File: rtl/ntt_defines_pkg.sv
// Shared types and constants for the masked NTT redux46 scheduling logic.
// Widths in redux_meta_t cover up to 4 requesters and tags up to 16 bits.
package ntt_defines_pkg;

    localparam int REDUX46_LATENCY = 157;
    localparam int REDUX_ID_W      = 2;
    localparam int REDUX_TAG_W     = 16;

    typedef logic [1:0][45:0] masked46_t;
    typedef logic [1:0][22:0] masked23_t;

    typedef struct packed {
        logic                   valid;
        logic [REDUX_ID_W-1:0]  id;
        logic [REDUX_TAG_W-1:0] tag;
    } redux_meta_t;

endpackage

// File: rtl/ntt_redux_rsp_fifo.sv
// Response FIFO holding {id, tag, masked result}; register storage so zeroize
// can wipe every entry. The head reads as all-zero whenever the FIFO is empty.
module ntt_redux_rsp_fifo
    import ntt_defines_pkg::*;
#(
    parameter int ID_W  = 1,
    parameter int TAG_W = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zeroize,
    input  logic             i_push,
    input  logic [ID_W-1:0]  i_id,
    input  logic [TAG_W-1:0] i_tag,
    input  masked23_t        i_y,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [ID_W-1:0]  o_id,
    output logic [TAG_W-1:0] o_tag,
    output masked23_t        o_y
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = ID_W + TAG_W + 46;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_pop;
    logic [DW-1:0] w_head;

    // The extra top pointer bit tells full from empty when the indices match.
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {i_id, i_tag, i_y};
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign w_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign {o_id, o_tag, o_y} = w_head;

endmodule

// File: rtl/ntt_masked_redux_sched.sv
// Shares one redux46 datapath between NUM_REQ requesters with credit-protected
// response buffering. NTT_REDUX_SCHED_RR_EN selects round-robin, else fixed priority.
module ntt_masked_redux_sched
    import ntt_defines_pkg::*;
#(
    parameter int LATENCY    = REDUX46_LATENCY,
    parameter int NUM_REQ    = 2,
    parameter int TAG_W      = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              zeroize,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag_i,
    input  masked46_t [NUM_REQ-1:0]           req_x_i,
    output logic [NUM_REQ-1:0]                req_gnt_o,
    output masked46_t                         redux_x_o,
    input  masked23_t                         redux_y_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id_o,
    output logic [TAG_W-1:0]                  rsp_tag_o,
    output masked23_t                         rsp_y_o,
    output logic                              busy_o
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]   r_outst;
    masked46_t       r_x;
    redux_meta_t     r_meta [LATENCY+1];
    redux_meta_t     w_meta_in;
    logic            w_can_issue;
    logic            w_found;
    logic            w_issue;
    logic [ID_W-1:0] w_gnt_id;
    logic [ID_W-1:0] w_base;
    int              w_idx;
    logic            w_push;
    logic            w_rsp_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;

    // Each credit reserves a FIFO slot, so a result can never arrive to a full FIFO.
    assign w_can_issue = (r_outst < CW'(FIFO_DEPTH)) && !zeroize && !rst;

`ifdef NTT_REDUX_SCHED_RR_EN
    logic [ID_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= ID_W'((int'(w_gnt_id) + 1) % NUM_REQ);
        end
    end

    assign w_base = r_ptr;
`else
    assign w_base = '0;
`endif

    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(w_base) + k) % NUM_REQ;
            if (!w_found && req_valid_i[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(w_idx);
            end
        end
    end

    assign w_issue = w_can_issue && w_found;

    always_comb begin
        req_gnt_o = '0;
        if (w_issue) begin
            req_gnt_o[w_gnt_id] = 1'b1;
        end
    end

    // Idle cycles load zero shares so no secret operand lingers on the datapath.
    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            r_x <= '0;
        end else begin
            r_x <= w_issue ? req_x_i[w_gnt_id] : '0;
        end
    end

    assign redux_x_o = r_x;

    always_comb begin
        w_meta_in = '0;
        if (w_issue) begin
            w_meta_in.valid = 1'b1;
            w_meta_in.id    = REDUX_ID_W'(w_gnt_id);
            w_meta_in.tag   = REDUX_TAG_W'(req_tag_i[w_gnt_id]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            for (int i = 0; i <= LATENCY; i++) begin
                r_meta[i] <= '0;
            end
        end else begin
            r_meta[0] <= w_meta_in;
            for (int i = 1; i <= LATENCY; i++) begin
                r_meta[i] <= r_meta[i-1];
            end
        end
    end

    assign rsp_valid_o = !w_fifo_empty;
    assign w_rsp_pop   = rsp_valid_o && rsp_ready_i;
    assign w_push      = r_meta[LATENCY].valid && (!w_fifo_full || w_rsp_pop);

    ntt_redux_rsp_fifo #(
        .ID_W  (ID_W),
        .TAG_W (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .zeroize (zeroize),
        .i_push  (w_push),
        .i_id    (r_meta[LATENCY].id[ID_W-1:0]),
        .i_tag   (r_meta[LATENCY].tag[TAG_W-1:0]),
        .i_y     (redux_y_i),
        .i_pop   (w_rsp_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_id    (rsp_id_o),
        .o_tag   (rsp_tag_o),
        .o_y     (rsp_y_o)
    );

    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            r_outst <= '0;
        end else if (w_issue && !w_rsp_pop) begin
            r_outst <= r_outst + CW'(1);
        end else if (!w_issue && w_rsp_pop) begin
            r_outst <= r_outst - CW'(1);
        end
    end

    assign busy_o = (r_outst != '0);

endmodule

// File: doc/ntt_masked_redux_sched.md
# ntt_masked_redux_sched

Scheduler that shares one `ntt_masked_mult_redux46` instance between `NUM_REQ` requesters, for example the masked PWM lanes and the masked INTT lane. It arbitrates issue slots and registers the winning 46-bit masked operand into the datapath. A metadata shift line tracks requester ID and tag through the fixed 157-cycle pipeline. Results are buffered in a credit-protected response FIFO so downstream backpressure never loses a result.

## Interface
- `LATENCY`, 157, redux46 datapath latency in cycles; must match the instance.
- `NUM_REQ`, 2, number of requesters (2..4).
- `TAG_W`, 6, opaque request tag width.
- `FIFO_DEPTH`, 8, response FIFO entries; also the credit limit (power of 2).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `zeroize` in 1: synchronous clear of all state and data; also drives the redux instance's `zeroize`.
- `req_valid_i` in NUM_REQ: per-requester request.
- `req_tag_i` in NUM_REQ×TAG_W: per-requester tag.
- `req_x_i` in NUM_REQ×46×2: per-requester Boolean-masked operand shares.
- `req_gnt_o` out NUM_REQ: one-hot grant; a handshake completes when `req_valid_i[i] & req_gnt_o[i]`.
- `redux_x_o` out 46×2: registered operand shares to the datapath.
- `redux_y_i` in 23×2: masked reduced result from the datapath.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: consumer accepts the response.
- `rsp_id_o` out clog2(NUM_REQ): originating requester.
- `rsp_tag_o` out TAG_W: originating tag.
- `rsp_y_o` out 23×2: result shares.
- `busy_o` out 1: any request in flight or buffered.

## Operation
- **Credit counter `outst`** (0..FIFO_DEPTH).
  - +1 on issue, −1 on response handshake; unchanged when both occur in the same cycle.
  - Issue is allowed only when `outst < FIFO_DEPTH`, `!zeroize` and `!rst`.
  - This guarantees a FIFO slot for every in-flight result.
- **Arbitration.**
  - Among valid requesters, exactly one `req_gnt_o` bit is high, and only when issue is allowed.
  - A grant is combinational from `req_valid_i` and the pointer.
  - Round-robin pointer: after a grant to requester i, priority starts at i+1 (mod NUM_REQ).
- **Issue register.**
  - On a handshake, `redux_x_o` loads the granted operand.
  - Otherwise it loads all-zero shares. It never holds stale secret data.
- **Metadata line.**
  - A LATENCY+1 deep shift register of {valid, id, tag}.
  - Entry 0 loads on issue; valid is 0 otherwise.
  - A valid bit at the tail marks the cycle in which `redux_y_i` carries that result.
- **Response FIFO write.** At the tail-valid cycle, {id, tag, `redux_y_i`} is written to the FIFO. Overflow is impossible by construction; the bench asserts it.
- **Response read.** The FIFO head drives `rsp_*_o`. Pop on `rsp_valid_o & rsp_ready_i`.
- **busy_o** = (`outst != 0`).
- **Zeroize and reset.**
  - Clear `outst`, the pointer (to requester 0), all metadata valid bits, the FIFO storage, the pointers and `redux_x_o`.
  - Clearing is effective at the next edge. In-flight requests are silently dropped.

## Timing
- Request accepted in cycle t:
  - `redux_x_o` valid in t+1;
  - `redux_y_i` valid in t+1+LATENCY (t+158);
  - written to the FIFO at the end of that cycle;
  - `rsp_valid_o` high in t+2+LATENCY (t+159) if the FIFO was empty.
- Throughput is one issue per cycle while credits remain. The sustained rate with a stalled consumer is bounded by FIFO_DEPTH outstanding.
- Reset value of every output is 0: `req_gnt_o`, `redux_x_o`, `rsp_valid_o`, `rsp_id_o`, `rsp_tag_o`, `rsp_y_o`, `busy_o`.
- FIFO full and a simultaneous pop: the write still succeeds, because credits already account for it.
- Pointer and counter wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
- `rsp_*_o` are driven from FIFO storage and are zero when empty.

## Configuration
- `NTT_REDUX_SCHED_RR_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest index wins. The pointer register is not implemented, and requester 0 can starve the others.

## Structure
- In `ntt_defines_pkg`:
  - `REDUX46_LATENCY` = 157;
  - typedefs `masked46_t` (`logic [1:0] [45:0]`) and `masked23_t`;
  - the metadata struct `redux_meta_t` {valid, id, tag}.
- One sub-module, `ntt_redux_rsp_fifo`: a synchronous FIFO of {id, tag, masked23_t} with push, pop, full, empty and zeroize.
- The redux46 instance stays outside this block; the scheduler only connects to it.

## Test plan
- **Single request:** requester 0, tag 0x15, x = 0 → `rsp_valid_o` first high exactly 159 cycles after the accept, with id 0, tag 0x15 and unmasked y = 0.
- **Back-to-back issue:** both requesters hold valid, `rsp_ready_i` = 1, with `NTT_REDUX_SCHED_RR_EN` defined → grants alternate 0,1,0,1; 8 responses return in issue order, one per cycle.
- **Credit stall:** `rsp_ready_i` = 0 and 8 issues → `req_gnt_o` is 0 from the 9th request; after one pop, exactly one more grant occurs; no FIFO overflow.
- **Fixed priority:** with the macro undefined and both requesters valid for 10 cycles → only requester 0 is granted.
- **Zeroize at cycle 80 with 5 requests in flight:** next cycle `busy_o` = 0 and `redux_x_o` = 0; no response ever appears; a new request after that returns normally 159 cycles later.
- **Idle leakage:** no requests → `redux_x_o` shares stay all-zero every cycle; reset mid-operation gives the same result as zeroize.
